// File: rtl/up_down_dir_decoder.sv
// Receive side of the up/down counter link: rebuilds the per-step direction
// command from successive count samples and flags steps that no legal command explains.
module up_down_dir_decoder #(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       count_in,
  input  logic             in_valid,
  input  logic             resync,
  input  logic             err_clr,
  output logic [1:0]       dir,
  output logic             dir_valid,
  output logic             jump_err,
  output logic [3:0]       run_len,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    TRACK = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    CODE_HOLD = 2'b00,
    CODE_UP   = 2'b01,
    CODE_DOWN = 2'b10,
    CODE_JUMP = 2'b11
  } code_e;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam logic [3:0]       RUN_MAX = 4'd15;

  state_e     state;
  logic [3:0] prev;
  logic [3:0] delta;
  code_e      code;
  logic       decode_en;
  logic       is_jump;
  logic [3:0] next_run_len;

  // A sample is decoded only while a reference is held; resync discards it.
  assign decode_en = in_valid && !resync && (state == TRACK);
  assign delta     = count_in - prev;  // 4-bit subtraction gives the mod-16 step
  assign is_jump   = decode_en && (code == CODE_JUMP);

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    code         = CODE_JUMP;
    next_run_len = 4'd0;
    unique case (delta)
      4'd0:    code = CODE_HOLD;
      4'd1:    code = CODE_UP;
      4'd15:   code = CODE_DOWN;
      default: code = CODE_JUMP;
    endcase
    // run_len==0 marks "no legal code since reset/jump/resync", so dir is
    // only a valid comparison reference when run_len is non-zero.
    if (code == CODE_JUMP) begin
      next_run_len = 4'd0;
    end else if (run_len != 4'd0 && code_e'(dir) == code) begin
      next_run_len = (run_len == RUN_MAX) ? RUN_MAX : run_len + 4'd1;
    end else begin
      next_run_len = 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      prev      <= 4'd0;
      dir       <= CODE_HOLD;
      dir_valid <= 1'b0;
      jump_err  <= 1'b0;
      run_len   <= 4'd0;
      err_cnt   <= '0;
    end else begin
      dir_valid <= 1'b0;
      jump_err  <= 1'b0;

      if (err_clr) begin
        err_cnt <= '0;
      end else if (is_jump && err_cnt != ERR_MAX) begin
        err_cnt <= err_cnt + 1'b1;
      end

      if (resync) begin
        state   <= EMPTY;
        run_len <= 4'd0;
      end else if (in_valid) begin
        prev <= count_in;
        if (state == EMPTY) begin
          state <= TRACK;
        end else begin
          dir       <= code;
          dir_valid <= 1'b1;
          jump_err  <= (code == CODE_JUMP);
          run_len   <= next_run_len;
        end
      end
    end
  end

endmodule

// File: tb/tb_up_down_dir_decoder.sv
// Scoreboard bench for up_down_dir_decoder: directed samples push expected
// pulses into a queue, and a negedge monitor pops and compares them.
module tb_up_down_dir_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] count_in = 4'd0;
  logic       in_valid = 1'b0;
  logic       resync = 1'b0;
  logic       err_clr = 1'b0;
  logic [1:0] dir;
  logic       dir_valid;
  logic       jump_err;
  logic [3:0] run_len;
  logic [7:0] err_cnt;

  typedef struct {
    logic [1:0] dir;
    logic [3:0] run_len;
    logic       jump_err;
    logic [7:0] err_cnt;
    int         due;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   edges = 0;

  up_down_dir_decoder #(.ERR_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .count_in (count_in),
    .in_valid (in_valid),
    .resync   (resync),
    .err_clr  (err_clr),
    .dir      (dir),
    .dir_valid(dir_valid),
    .jump_err (jump_err),
    .run_len  (run_len),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges++;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every pulse must match the oldest expectation, on its due edge.
  always @(negedge clk) begin
    exp_t e;
    total++;
    if (jump_err && !dir_valid) begin
      bad++;
      $display("FAIL jump_err_alone: jump_err=1 with dir_valid=0 at edge %0d", edges);
    end
    if (dir_valid) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: dir=%0d run_len=%0d at edge %0d, none expected",
                 dir, run_len, edges);
      end else begin
        e = q.pop_front();
        if (dir !== e.dir || run_len !== e.run_len || jump_err !== e.jump_err ||
            err_cnt !== e.err_cnt || edges != e.due) begin
          bad++;
          $display("FAIL pulse: got dir=%0d rl=%0d je=%0d err=%0d edge=%0d expected dir=%0d rl=%0d je=%0d err=%0d edge=%0d",
                   dir, run_len, jump_err, err_cnt, edges,
                   e.dir, e.run_len, e.jump_err, e.err_cnt, e.due);
        end
      end
    end
  end

  task automatic step(input logic v, input logic [3:0] c,
                      input logic rs = 1'b0, input logic clr = 1'b0);
    @(negedge clk);
    in_valid = v;
    count_in = c;
    resync   = rs;
    err_clr  = clr;
  endtask

  task automatic expect_pulse(input logic [1:0] d, input logic [3:0] rl,
                              input logic je, input logic [7:0] ec);
    q.push_back('{dir: d, run_len: rl, jump_err: je, err_cnt: ec, due: edges + 1});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; resync = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    check("reset_dir", dir, 0);
    check("reset_dir_valid", dir_valid, 0);
    check("reset_jump_err", jump_err, 0);
    check("reset_run_len", run_len, 0);
    check("reset_err_cnt", err_cnt, 0);

    // First sample only loads the reference.
    step(1, 3);
    step(1, 4); expect_pulse(2'b01, 1, 0, 0);
    step(1, 5); expect_pulse(2'b01, 2, 0, 0);

    // Mid-stream reset drops the reference; wrap-around in both directions.
    do_reset();
    step(1, 14);
    step(1, 15); expect_pulse(2'b01, 1, 0, 0);
    step(1, 0);  expect_pulse(2'b01, 2, 0, 0);
    step(1, 15); expect_pulse(2'b10, 1, 0, 0);
    step(1, 14); expect_pulse(2'b10, 2, 0, 0);

    // Holds then an illegal jump.
    do_reset();
    step(1, 5);
    step(1, 5); expect_pulse(2'b00, 1, 0, 0);
    step(1, 5); expect_pulse(2'b00, 2, 0, 0);
    step(1, 9); expect_pulse(2'b11, 0, 1, 1);

    // Gap of idle cycles between samples.
    step(1, 6); expect_pulse(2'b11, 0, 1, 2);
    idle(3);
    step(1, 7); expect_pulse(2'b01, 1, 0, 2);

    // Resync coincident with a sample.
    step(1, 2); expect_pulse(2'b11, 0, 1, 3);
    step(1, 3); expect_pulse(2'b01, 1, 0, 3);
    step(1, 7, 1'b1);
    step(1, 8);
    step(1, 9); expect_pulse(2'b01, 1, 0, 3);

    // Long up-run: run_len saturates at 15.
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(10 + i);
      step(1, v);
      expect_pulse(2'b01, 4'((i + 2 > 15) ? 15 : i + 2), 0, 3);
    end

    // err_clr with no sample.
    step(0, 0, 1'b0, 1'b1);
    step(0, 0);
    check("err_clr_alone", err_cnt, 0);

    // 256 jumps: err_cnt climbs to 255 and sticks.
    for (int i = 0; i < 256; i++) begin
      step(1, (i % 2 == 0) ? 4'd1 : 4'd9);
      expect_pulse(2'b11, 0, 1, 8'((i + 1 > 255) ? 255 : i + 1));
    end
    step(0, 0);
    check("err_cnt_saturated", err_cnt, 255);

    // err_clr wins over a simultaneous jump; next legal code restarts at 1.
    step(1, 1, 1'b0, 1'b1); expect_pulse(2'b11, 0, 1, 0);
    step(1, 2);             expect_pulse(2'b01, 1, 0, 0);

    // Resync without a sample clears run_len but keeps dir and err_cnt.
    step(0, 0, 1'b1);
    step(0, 0);
    check("resync_run_len", run_len, 0);
    check("resync_dir_hold", dir, 1);
    check("resync_err_cnt", err_cnt, 0);
    step(1, 5);
    step(1, 6); expect_pulse(2'b01, 1, 0, 0);

    idle(4);
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
